sin_sweep_ctrl: RTL

Synthesizable sequencer that drives the sinusoid stimulus source of the SAR-ADC model through a programmed list of tones. For each tone it loads a frequency tuning word (FTW) into the stimulus generator and clears the generator's phase. It then waits a fixed settling time and streams a fixed-length capture window to the downstream sample-capture block over a valid/ready handshake. It sits between the test/config interface and the stimulus generator / capture pair, and sequences both.

---
 rtl/sin_sweep_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sin_sweep_ctrl.sv
// rtl/sin_sweep_ctrl.sv - tone-sweep sequencer for the SAR-ADC sinusoid stimulus and capture window
module sin_sweep_ctrl #(
  parameter int NUM_TONES   = 4,
  parameter int FTW_W       = 24,
  parameter int SETTLE_CYC  = 16,
  parameter int CAPTURE_LEN = 64,
  parameter int IDX_W       = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ftw_wr_en,
  input  logic [IDX_W-1:0] ftw_wr_addr,
  input  logic [FTW_W-1:0] ftw_wr_data,
  output logic             gen_en,
  output logic [FTW_W-1:0] gen_ftw,
  output logic             gen_phase_clr,
  output logic             cap_valid,
  output logic             cap_last,
  input  logic             cap_ready,
  output logic [IDX_W-1:0] tone_idx,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  // Counter widths cover the full settle/capture lengths so neither can wrap.
  localparam int SC_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int CC_W = $clog2(CAPTURE_LEN + 1);
  // The table is padded to a power of two so any address is a legal index;
  // entries at NUM_TONES and above are never written and never read.
  localparam int TBL_DEPTH = 2 ** IDX_W;

  localparam logic [SC_W-1:0]  SETTLE_LAST = (SETTLE_CYC > 0) ? SC_W'(SETTLE_CYC - 1) : '0;
  localparam logic [CC_W-1:0]  CAP_LAST    = CC_W'(CAPTURE_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_TONE   = IDX_W'(NUM_TONES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SC_W-1:0]    set_cnt_q, set_cnt_d;
  logic [CC_W-1:0]    cap_cnt_q, cap_cnt_d;
  logic [IDX_W-1:0]   tone_idx_q, tone_idx_d;
  logic [FTW_W-1:0]   gen_ftw_q, gen_ftw_d;
  logic               gen_en_q, gen_en_d;
  logic               phase_clr_q, phase_clr_d;
  logic               cap_valid_q, cap_valid_d;
  logic               cap_last_q, cap_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;

  logic [FTW_W-1:0]   tbl_q [TBL_DEPTH];

  // Tuning-word table; out-of-range writes are dropped. Reads elsewhere see the pre-write value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TBL_DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (ftw_wr_en && (32'(ftw_wr_addr) < NUM_TONES)) begin
      tbl_q[ftw_wr_addr] <= ftw_wr_data;
    end
  end

  // Next-state and next-output decode; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d    = state_q;
    set_cnt_d  = set_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    tone_idx_d = tone_idx_q;
    gen_ftw_d  = gen_ftw_q;
    aborted_d  = 1'b0;

    if (abort && (state_q != IDLE)) begin
      // Abort beats every other transition, including a completing last handshake.
      state_d   = IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = LOAD;
            tone_idx_d = '0;
            gen_ftw_d  = tbl_q[0];
          end
        end
        LOAD: begin
          set_cnt_d = '0;
          cap_cnt_d = '0;
          if (SETTLE_CYC == 0) begin
            state_d = CAPTURE;
          end else begin
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (set_cnt_q == SETTLE_LAST) begin
            state_d   = CAPTURE;
            cap_cnt_d = '0;
          end else begin
            set_cnt_d = set_cnt_q + SC_W'(1);
          end
        end
        CAPTURE: begin
          if (cap_ready) begin
            if (cap_cnt_q == CAP_LAST) begin
              if (tone_idx_q == LAST_TONE) begin
                state_d = DONE;
              end else begin
                state_d    = LOAD;
                tone_idx_d = tone_idx_q + IDX_W'(1);
                gen_ftw_d  = tbl_q[tone_idx_q + IDX_W'(1)];
              end
            end else begin
              cap_cnt_d = cap_cnt_q + CC_W'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    gen_en_d    = (state_d == LOAD) || (state_d == SETTLE) || (state_d == CAPTURE);
    phase_clr_d = (state_d == LOAD);
    cap_valid_d = (state_d == CAPTURE);
    cap_last_d  = (state_d == CAPTURE) && (cap_cnt_d == CAP_LAST);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      set_cnt_q   <= '0;
      cap_cnt_q   <= '0;
      tone_idx_q  <= '0;
      gen_ftw_q   <= '0;
      gen_en_q    <= 1'b0;
      phase_clr_q <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      tone_idx_q  <= tone_idx_d;
      gen_ftw_q   <= gen_ftw_d;
      gen_en_q    <= gen_en_d;
      phase_clr_q <= phase_clr_d;
      cap_valid_q <= cap_valid_d;
      cap_last_q  <= cap_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign gen_en        = gen_en_q;
  assign gen_ftw       = gen_ftw_q;
  assign gen_phase_clr = phase_clr_q;
  assign cap_valid     = cap_valid_q;
  assign cap_last      = cap_last_q;
  assign tone_idx      = tone_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule
